l1_dcache_wb: RTL
=================

Name: l1_dcache_wb

Overview:
Direct-mapped, write-back, write-allocate L1 data cache. It is the responder on the processor-side cache interface that the pipeline core drives: ren/wen, 30-bit word address, wdata; it returns stall and rdata. On a miss it initiates 128-bit line transfers to main memory. Its port set also fits the I-cache slot, with proc_write tied low.

Parameters:
NUM_LINES, 8, number of cache lines; power of two, 2 to 64; INDEX_W = log2(NUM_LINES)
LINE_WORDS, 4, words per line; fixed at 4, not overridable

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
proc_read  input  1  processor read request
proc_write  input  1  processor write request
proc_addr  input  30  word address; [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
proc_wdata  input  32  write data
proc_stall  output  1  high while the request cannot complete this cycle
proc_rdata  output  32  read data; valid when proc_read=1 and proc_stall=0
mem_read  output  1  line fill request
mem_write  output  1  line write-back request
mem_addr  output  28  line address (word address >> 2)
mem_wdata  output  128  line being written back; word0 in [31:0]
mem_rdata  input  128  fill data; valid only in the mem_ready cycle; word0 in [31:0]
mem_ready  input  1  one-cycle pulse; completes the current mem_read or mem_write

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid and dirty bits cleared. Outputs: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0. Tag and data arrays need no reset.
- Reset during WRITEBACK or ALLOCATE: the transfer is abandoned, and mem_read/mem_write drop immediately (asynchronously).
- Request = proc_read | proc_write. If both are high, the access is a write.
- Processor holds request, address and data stable while proc_stall=1.
- Hit = valid[index] & (tag[index] == addr tag).
- State IDLE:
  - No request: proc_stall=0; no state change.
  - Hit: proc_stall=0 in the same cycle (combinational, zero added latency).
    - Read: proc_rdata = data[index][offset], combinational.
    - Write: the word is updated and dirty[index] set at the clock edge.
  - Miss with line clean or invalid: proc_stall=1; next state ALLOCATE.
  - Miss with line valid and dirty: proc_stall=1; next state WRITEBACK.
- State WRITEBACK:
  - Outputs: mem_write=1, mem_addr={stored tag, index}, mem_wdata=stored line, proc_stall=1.
  - Holds until mem_ready, then ALLOCATE.
- State ALLOCATE:
  - Outputs: mem_read=1, mem_addr=proc_addr[29:2], proc_stall=1.
  - On mem_ready: line<=mem_rdata, tag written, valid=1, dirty=0; next state IDLE.
- After ALLOCATE, the held request hits in IDLE on the next cycle. A write miss merges its word then and sets dirty.
- Miss latency: clean miss = mem wait + 2 cycles; dirty miss = 2 mem waits + 3 cycles.
- mem_read and mem_write are never both high. Each stays asserted, with a constant address, until mem_ready. A mem_ready seen in IDLE is ignored.
- mem_addr and mem_wdata are registered/held per state. In IDLE they hold their last value and are don't-care.
- proc_rdata is don't-care when proc_read=0 or proc_stall=1.

Test Plan:
- After reset, read addr 0x0000010 → proc_stall=1 and mem_read=1 with mem_addr=0x0000004. Return mem_ready with mem_rdata={D,C,B,A} → next cycle proc_stall=0 and proc_rdata=A.
- Read hit 0x0000011 following the previous fill → proc_stall=0 in the same cycle, proc_rdata=B, mem_read stays 0.
- Write 0xDEADBEEF to 0x0000012 (hit) → no stall. A subsequent read of 0x0000012 returns 0xDEADBEEF.
- With NUM_LINES=8, read 0x0000032 (same index 4, tag differs, line dirty) → mem_write=1, mem_addr=0x0000004, mem_wdata[95:64]=0xDEADBEEF. After mem_ready, mem_read=1 with mem_addr=0x000000C. After the next mem_ready, no stall.
- Write miss to clean line 0x0000040 with wdata 0x12345678 → fill occurs, then the word merges. Evicting that line later writes back word0=0x12345678.
- Drop rst_n mid-ALLOCATE while holding mem_ready low for 5 cycles → mem_read=0 immediately. After reset, the same address misses again (valid cleared).

Source files
------------

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 128-bit line refill/eviction.
// Hits complete combinationally in IDLE; misses walk WRITEBACK (if dirty) then ALLOCATE.
module l1_dcache_wb #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [127:0]         r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [27:0]          r_mem_addr;
  logic [127:0]         r_mem_wdata;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_offset;
  logic [127:0]       w_line;
  logic               w_req;
  logic               w_hit;
  logic               w_stall;
  logic               w_ld_wb;
  logic               w_ld_alloc;
  logic               w_fill;
  logic               w_wr_hit;

  assign w_index  = proc_addr[INDEX_W+1:2];
  assign w_tag    = proc_addr[29:INDEX_W+2];
  assign w_offset = proc_addr[1:0];
  assign w_line   = r_data[w_index];
  assign w_req    = proc_read | proc_write;
  assign w_hit    = r_valid[w_index] & (r_tag[w_index] == w_tag);

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_ld_wb     = 1'b0;
    w_ld_alloc  = 1'b0;
    w_fill      = 1'b0;
    w_wr_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_wr_hit = proc_write;
          end else begin
            w_stall = 1'b1;
            if (r_valid[w_index] & r_dirty[w_index]) begin
              w_state_nxt = S_WRITEBACK;
              w_ld_wb     = 1'b1;
            end else begin
              w_state_nxt = S_ALLOCATE;
              w_ld_alloc  = 1'b1;
            end
          end
        end else begin
          w_stall = 1'b0;
        end
      end
      S_WRITEBACK: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_ALLOCATE;
          w_ld_alloc  = 1'b1;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_IDLE;
          w_fill      = 1'b1;
        end else begin
          w_state_nxt = S_ALLOCATE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Line status bits and memory-side address/data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_addr  <= 28'd0;
      r_mem_wdata <= 128'd0;
    end else begin
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_wr_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_ld_wb) begin
        r_mem_addr  <= {r_tag[w_index], w_index};
        r_mem_wdata <= w_line;
      end else if (w_ld_alloc) begin
        r_mem_addr  <= proc_addr[29:2];
      end
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= mem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_index][{w_offset, 5'd0} +: 32] <= proc_wdata;
    end
  end

  // Stall is masked in reset so the interface reads idle while rst_n is low
  assign proc_stall = w_stall & rst_n;
  assign proc_rdata = w_hit ? w_line[{w_offset, 5'd0} +: 32] : 32'd0;
  assign mem_read   = (r_state == S_ALLOCATE);
  assign mem_write  = (r_state == S_WRITEBACK);
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
